// File: rtl/press_pkg.sv
// Shared input-handling definitions: gesture FSM states and default timing
// constants for a 50 MHz system clock.
package press_pkg;

  typedef enum logic [2:0] {
    ST_ARM       = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PRESS1    = 3'd2,
    ST_GAP       = 3'd3,
    ST_PRESS2    = 3'd4,
    ST_LONG_HOLD = 3'd5
  } state_e;

  localparam int unsigned CLK_HZ      = 32'd50_000_000;
  localparam int unsigned LONG_CYCLES = CLK_HZ;
  localparam int unsigned GAP_CYCLES  = CLK_HZ / 32'd4;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser with a parameterised reset value.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/press_classifier.sv
// Turns the debounced button level into short, long and double press pulses
// plus a held level, timing presses and gaps with one shared counter.
module press_classifier #(
  parameter int unsigned LONG_CYCLES = press_pkg::LONG_CYCLES,
  parameter int unsigned GAP_CYCLES  = press_pkg::GAP_CYCLES,
  parameter int unsigned CNT_W       = 27
) (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held
);

  import press_pkg::*;

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES - 32'd1);

  logic             level_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_s;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             held_q, held_d;

  // Idle-high reset so a button already down at reset is not taken as a press.
  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (level),
    .q       (level_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ARM;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    lim_s    = (state_q == ST_GAP) ? GAP_LIM : LONG_LIM;
    cnt_d    = (cnt_q >= lim_s) ? lim_s : cnt_q + CNT_W'(1);

    // Level changes are tested before timeouts so an edge on the last count wins.
    case (state_q)
      ST_ARM: begin
        if (!level_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (level_s) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (!level_s) begin
          state_d = ST_GAP;
        end else if (cnt_q == LONG_LIM) begin
          state_d = ST_LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (level_s) begin
          state_d = ST_PRESS2;
        end else if (cnt_q == GAP_LIM) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (!level_s) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end else if (cnt_q == LONG_LIM) begin
          state_d = ST_LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      ST_LONG_HOLD: begin
        if (!level_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    held_d = (state_d == ST_LONG_HOLD);
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign held         = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG_CYCLES=16, GAP_CYCLES=8.
module tb_press_classifier;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic level = 1'b1;
  logic short_press, long_press, double_press, held;

  press_classifier #(.LONG_CYCLES(16), .GAP_CYCLES(8), .CNT_W(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .level        (level),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_short = 0, n_long = 0, n_dbl = 0, n_multi = 0;
  int last_short = -1, last_long = -1, last_dbl = -1;
  int held_rise = -1, held_fall = -1;
  logic held_prev = 1'b0;

  // Event monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (short_press)  begin n_short <= n_short + 1; last_short <= cyc; end
    if (long_press)   begin n_long  <= n_long + 1;  last_long  <= cyc; end
    if (double_press) begin n_dbl   <= n_dbl + 1;   last_dbl   <= cyc; end
    if (32'(short_press) + 32'(long_press) + 32'(double_press) > 1) n_multi <= n_multi + 1;
    if (held && !held_prev) held_rise <= cyc;
    if (!held && held_prev) held_fall <= cyc;
    held_prev <= held;
  end

  int n_checks = 0, n_errors = 0;
  int b_s, b_l, b_d, p, r;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic snap();
    b_s = n_short; b_l = n_long; b_d = n_dbl;
  endtask

  initial begin
    // Reset with the button already down.
    level = 1'b1; reset_n = 1'b0;
    tick(3);
    check("rst_short", 32'(short_press), 0);
    check("rst_long", 32'(long_press), 0);
    check("rst_double", 32'(double_press), 0);
    check("rst_held", 32'(held), 0);
    reset_n = 1'b1;
    tick(30);
    level = 1'b0;
    tick(6);
    check("arm_quiet", n_short + n_long + n_dbl, 0);

    // Single short click.
    snap();
    level = 1'b1; tick(5); level = 1'b0; r = cyc; tick(20);
    check("s1_short_n", n_short - b_s, 1);
    check("s1_short_cyc", last_short, r + 11);
    check("s1_other", (n_long - b_l) + (n_dbl - b_d), 0);

    // Double click.
    snap();
    level = 1'b1; tick(5); level = 1'b0; tick(3);
    level = 1'b1; tick(5); level = 1'b0; r = cyc; tick(25);
    check("s2_dbl_n", n_dbl - b_d, 1);
    check("s2_dbl_cyc", last_dbl, r + 3);
    check("s2_other", (n_short - b_s) + (n_long - b_l), 0);

    // Long hold for 40 cycles.
    snap();
    level = 1'b1; p = cyc; tick(30);
    check("s3_held_mid", 32'(held), 1);
    tick(10); level = 1'b0; r = cyc; tick(15);
    check("s3_long_n", n_long - b_l, 1);
    check("s3_long_cyc", last_long, p + 19);
    check("s3_held_rise", held_rise, p + 19);
    check("s3_held_fall", held_fall, r + 3);
    check("s3_other", (n_short - b_s) + (n_dbl - b_d), 0);

    // Release seen on the final count of PRESS1: level change wins.
    snap();
    level = 1'b1; tick(16); level = 1'b0; r = cyc; tick(20);
    check("s4a_no_long", n_long - b_l, 0);
    check("s4a_short_n", n_short - b_s, 1);
    check("s4a_short_cyc", last_short, r + 11);

    // Re-press seen on the final count of GAP: level change wins.
    snap();
    level = 1'b1; tick(5); level = 1'b0; tick(8);
    level = 1'b1; tick(2); level = 1'b0; r = cyc; tick(20);
    check("s4b_no_short", n_short - b_s, 0);
    check("s4b_dbl_n", n_dbl - b_d, 1);
    check("s4b_dbl_cyc", last_dbl, r + 3);

    // Click, then a second press held long.
    snap();
    level = 1'b1; tick(5); level = 1'b0; tick(3);
    level = 1'b1; p = cyc; tick(20); level = 1'b0; tick(20);
    check("s5_long_n", n_long - b_l, 1);
    check("s5_long_cyc", last_long, p + 19);
    check("s5_other", (n_short - b_s) + (n_dbl - b_d), 0);

    // Reset mid-gap drops the pending short press.
    snap();
    level = 1'b1; tick(5); level = 1'b0; tick(6);
    reset_n = 1'b0; #1;
    check("s6_rst_outs", 32'(short_press) + 32'(long_press) + 32'(double_press) + 32'(held), 0);
    tick(3); reset_n = 1'b1; tick(30);
    check("s6_no_event", (n_short - b_s) + (n_long - b_l) + (n_dbl - b_d), 0);

    // Reset during LONG_HOLD clears held at once.
    snap();
    level = 1'b1; tick(25);
    check("s7_held_pre", 32'(held), 1);
    reset_n = 1'b0; #1;
    check("s7_held_rst", 32'(held), 0);
    tick(2); level = 1'b0; reset_n = 1'b1; tick(12);
    check("s7_long_n", n_long - b_l, 1);
    check("s7_other", (n_short - b_s) + (n_dbl - b_d), 0);
    check("one_event_per_cycle", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
